// File: rtl/tt_uart.sv
// 8N1 UART core: console-side four-phase handshakes on both directions,
// physical txd/rxd pins, bit timing derived from the system clock.
module tt_uart #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic       tx_empty,
    output logic       txd,
    input  logic       rxd,
    input  logic       rx_req,
    output logic       rx_ack,
    output logic       rx_empty,
    output logic [7:0] rx_data,
    output logic       rx_ferr,
    output logic       rx_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_SEND = 2'd1;
    localparam logic [1:0] TX_DONE = 2'd2;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_accept;
    logic          tx_tick;

    assign tx_accept = (tx_state == TX_IDLE) && tx_req && !tx_ack;
    assign tx_tick   = (tx_state == TX_SEND) && (tx_cnt == BIT_LAST);

    // tx_bit 0 is the start bit, 1..8 data, 9 stop; the shifter back-fills ones for the stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            txd      <= 1'b1;
            tx_ack   <= 1'b0;
            tx_empty <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= 4'd0;
        end else begin
            if (tx_ack && !tx_req)
                tx_ack <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_ack   <= 1'b1;
                        tx_empty <= 1'b0;
                        txd      <= 1'b0;
                        tx_cnt   <= '0;
                        tx_bit   <= 4'd0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            // skip the DONE wait when the console has already released
                            if (!tx_ack) begin
                                tx_empty <= 1'b1;
                                tx_state <= TX_IDLE;
                            end else begin
                                tx_state <= TX_DONE;
                            end
                        end else begin
                            txd    <= tx_shift[0];
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DONE: begin
                    if (!tx_ack) begin
                        tx_empty <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_accept)
            tx_shift <= tx_data;
        else if (tx_tick && (tx_bit != 4'd9))
            tx_shift <= {1'b1, tx_shift[7:1]};
    end

    logic          rxd_p0;
    logic          rxd_p1;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    // rxd is asynchronous: two-flop synchronizer, idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_ack     <= 1'b0;
            rx_empty   <= 1'b1;
            rx_data    <= 8'h00;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rxd_p1) begin
                        rx_cnt   <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rxd_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_state <= RX_IDLE;
                        if (!rxd_p1) begin
                            rx_ferr <= 1'b1;
                        end else if (rx_empty) begin
                            rx_data  <= rx_shift;
                            rx_empty <= 1'b0;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
            // a load needs rx_empty=1 and a release needs rx_ack=1, so they never coincide
            if (rx_req && !rx_empty && !rx_ack) begin
                rx_ack <= 1'b1;
            end else if (rx_ack && !rx_req) begin
                rx_ack   <= 1'b0;
                rx_empty <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((rx_state == RX_DATA) && (rx_cnt == BIT_LAST))
            rx_shift <= {rxd_p1, rx_shift[7:1]};
    end
endmodule

// File: tb/tb_tt_uart.sv
// Bench for tt_uart at 16 clocks per bit: frame-level model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_tt_uart;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ack, tx_empty, txd;
    logic       rxd_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rxd;
    logic       rx_req = 1'b0;
    logic       rx_ack, rx_empty, rx_ferr, rx_overrun;
    logic [7:0] rx_data;

    assign rxd = loop ? txd : rxd_drv;

    tt_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset),
        .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .tx_empty(tx_empty), .txd(txd),
        .rxd(rxd), .rx_req(rx_req), .rx_ack(rx_ack), .rx_empty(rx_empty), .rx_data(rx_data),
        .rx_ferr(rx_ferr), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] b;
        logic       ok;
    } rx_ev_t;

    rx_ev_t     rxq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;

    logic       m_tx_busy = 1'b0;
    logic       m_tx_ack = 1'b0;
    int         m_tx_start = 0;
    logic [7:0] m_tx_byte = 8'h00;
    logic       m_rx_empty = 1'b1;
    logic       m_rx_ack = 1'b0;
    logic [7:0] m_rx_data = 8'h00;
    logic       e_ferr = 1'b0;
    logic       e_ovr = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a frame occupies 10 bit times from its accept edge; a received frame
    // resolves 155 cycles after its start bit appears on the line.
    always @(posedge clk) begin : model
        logic old_tx_ack;
        logic old_rx_empty;
        rx_ev_t ev;
        cyc = cyc + 1;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        if (reset) begin
            m_tx_busy  = 1'b0;
            m_tx_ack   = 1'b0;
            m_rx_empty = 1'b1;
            m_rx_ack   = 1'b0;
            m_rx_data  = 8'h00;
            rxq.delete();
        end else begin
            old_tx_ack   = m_tx_ack;
            old_rx_empty = m_rx_empty;
            if (!m_tx_busy && tx_req && !m_tx_ack) begin
                m_tx_busy  = 1'b1;
                m_tx_ack   = 1'b1;
                m_tx_start = cyc;
                m_tx_byte  = tx_data;
                if (loop) rxq.push_back('{cyc + 155, tx_data, 1'b1});
            end else if (m_tx_ack && !tx_req) begin
                m_tx_ack = 1'b0;
            end
            if (m_tx_busy && (cyc - m_tx_start) >= 10*CPB && !old_tx_ack)
                m_tx_busy = 1'b0;
            if (rxq.size() > 0 && rxq[0].at == cyc) begin
                ev = rxq.pop_front();
                if (!ev.ok) e_ferr = 1'b1;
                else if (old_rx_empty) begin
                    m_rx_empty = 1'b0;
                    m_rx_data  = ev.b;
                end else e_ovr = 1'b1;
            end
            if (rx_req && !old_rx_empty && !m_rx_ack) m_rx_ack = 1'b1;
            else if (m_rx_ack && !rx_req) begin
                m_rx_ack   = 1'b0;
                m_rx_empty = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_txd;
        if (cyc > 0) begin
            exp_txd = 1'b1;
            if (m_tx_busy && (cyc - m_tx_start) < 10*CPB)
                exp_txd = frame_bit(m_tx_byte, (cyc - m_tx_start) / CPB);
            chk("txd", txd, exp_txd);
            chk("tx_empty", tx_empty, !m_tx_busy);
            chk("tx_ack", tx_ack, m_tx_ack);
            chk("rx_empty", rx_empty, m_rx_empty);
            chk("rx_ack", rx_ack, m_rx_ack);
            chk("rx_data", rx_data, m_rx_data);
            chk("rx_ferr", rx_ferr, e_ferr);
            chk("rx_overrun", rx_overrun, e_ovr);
            if (rx_ferr) n_ferr++;
            if (rx_overrun) n_ovr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_rx_full(input int budget, output int at);
        int k = 0;
        while (rx_empty && k < budget) begin
            tick();
            k++;
        end
        chk("rx_full_wait", rx_empty, 1'b0);
        at = cyc;
    endtask

    task automatic tx_send(input logic [7:0] b, output int acc);
        int k = 0;
        while (!tx_empty && k < 500) begin
            tick();
            k++;
        end
        chk("tx_idle_wait", tx_empty, 1'b1);
        tx_data = b;
        tx_req  = 1'b1;
        tick();
        chk("tx_ack_rise", tx_ack, 1'b1);
        acc    = cyc;
        tx_req = 1'b0;
        tick();
        chk("tx_ack_fall", tx_ack, 1'b0);
    endtask

    task automatic rx_drive(input logic [7:0] b, input logic stop);
        rxq.push_back('{cyc + 155, b, stop});
        for (int k = 0; k < 10; k++) begin
            rxd_drv = (k == 9) ? stop : frame_bit(b, k);
            repeat (CPB) tick();
        end
        rxd_drv = 1'b1;
    endtask

    task automatic rx_read(output logic [7:0] d);
        rx_req = 1'b1;
        tick();
        chk("rx_ack_rise", rx_ack, 1'b1);
        d      = rx_data;
        rx_req = 1'b0;
        tick();
        chk("rx_ack_fall", rx_ack, 1'b0);
        chk("rx_empty_after_read", rx_empty, 1'b1);
    endtask

    initial begin
        int acc, st, at, f0, o0;
        logic [7:0] d;

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_txd", txd, 1'b1);
        chk("rst_tx_empty", tx_empty, 1'b1);
        chk("rst_tx_ack", tx_ack, 1'b0);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        repeat (2) tick();

        // TX 0x55
        tx_send(8'h55, acc);
        wait_cyc(acc + 15);  chk("tx55_start", txd, 1'b0);
        wait_cyc(acc + 16);  chk("tx55_d0", txd, 1'b1);
        wait_cyc(acc + 32);  chk("tx55_d1", txd, 1'b0);
        wait_cyc(acc + 128); chk("tx55_d7", txd, 1'b0);
        wait_cyc(acc + 144); chk("tx55_stop", txd, 1'b1);
        wait_cyc(acc + 159); chk("tx55_busy_159", tx_empty, 1'b0);
        wait_cyc(acc + 160); chk("tx55_empty_160", tx_empty, 1'b1);
        repeat (4) tick();

        // RX 0xA3
        st = cyc;
        fork
            rx_drive(8'hA3, 1'b1);
        join_none
        wait_rx_full(300, at);
        chk("rxA3_full_cycle", at, st + 155);
        rx_read(d);
        chk("rxA3_data", d, 8'hA3);
        wait_cyc(st + 170);

        // glitch
        f0 = n_ferr;
        rxd_drv = 1'b0;
        repeat (4) tick();
        rxd_drv = 1'b1;
        repeat (40) tick();
        chk("glitch_ferr", n_ferr - f0, 0);
        chk("glitch_empty", rx_empty, 1'b1);

        // framing error
        f0 = n_ferr;
        rx_drive(8'h3C, 1'b0);
        repeat (30) tick();
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_empty", rx_empty, 1'b1);

        // overrun
        f0 = n_ferr;
        o0 = n_ovr;
        rx_drive(8'h11, 1'b1);
        rx_drive(8'h22, 1'b1);
        repeat (10) tick();
        chk("ovr_count", n_ovr - o0, 1);
        chk("ovr_no_ferr", n_ferr - f0, 0);
        rx_read(d);
        chk("ovr_kept_first", d, 8'h11);
        repeat (5) tick();

        // reset during data bit 3
        tx_send(8'h5A, acc);
        wait_cyc(acc + 70);
        reset = 1'b1;
        tick();
        chk("rstmid_txd", txd, 1'b1);
        chk("rstmid_tx_empty", tx_empty, 1'b1);
        chk("rstmid_tx_ack", tx_ack, 1'b0);
        reset = 1'b0;
        repeat (3) tick();

        // loopback
        loop = 1'b1;
        f0 = n_ferr;
        o0 = n_ovr;
        tx_send(8'h00, acc);
        wait_rx_full(400, at);
        chk("loop00_full_cycle", at, acc + 155);
        rx_read(d);
        chk("loop00_data", d, 8'h00);
        tx_send(8'hFF, acc);
        wait_rx_full(400, at);
        rx_read(d);
        chk("loopFF_data", d, 8'hFF);
        wait_cyc(acc + 170);
        chk("loop_ferr", n_ferr - f0, 0);
        chk("loop_ovr", n_ovr - o0, 0);
        chk("loop_tx_empty", tx_empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
